// File: rtl/sram_uart_dump.sv
// Streams a contiguous SRAM region out of an 8N1 UART transmitter, two bytes per word, high byte first.
// The next word is prefetched while the low byte is on the line, so frames follow each other with no idle gap.
module sram_uart_dump #(
    parameter int CLKS_PER_BIT = 434,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_W       = 18
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Base_address,
    input  logic [ADDR_W-1:0] Word_count,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic              SRAM_we_n,
    input  logic [15:0]       SRAM_read_data,
    output logic              UART_TX_O
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int WAIT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    // FETCH plus WAIT span READ_LATENCY cycles (READ_LATENCY >= 2 assumed)
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((READ_LATENCY > 2) ? READ_LATENCY - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_TX_HI,
        S_TX_LO,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [ADDR_W-1:0]   remaining_reg, remaining_next;
    logic [15:0]         cur_word_reg, cur_word_next;
    logic [15:0]         next_word_reg, next_word_next;
    logic [BAUD_W-1:0]   baud_reg, baud_next;
    logic [3:0]          bit_reg, bit_next;
    logic [WAIT_W-1:0]   wait_reg, wait_next;
    logic                tx_reg, tx_next;
    logic [READ_LATENCY:0] issue_reg, issue_next;
    logic                issue_now;
    logic [7:0]          tx_byte;
    logic                baud_wrap;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            cur_word_reg  <= '0;
            next_word_reg <= '0;
            baud_reg      <= '0;
            bit_reg       <= '0;
            wait_reg      <= '0;
            tx_reg        <= 1'b1;
            issue_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            cur_word_reg  <= cur_word_next;
            next_word_reg <= next_word_next;
            baud_reg      <= baud_next;
            bit_reg       <= bit_next;
            wait_reg      <= wait_next;
            tx_reg        <= tx_next;
            issue_reg     <= issue_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        cur_word_next  = cur_word_reg;
        next_word_next = next_word_reg;
        baud_next      = baud_reg;
        bit_next       = bit_reg;
        wait_next      = wait_reg;
        tx_next        = tx_reg;
        issue_now      = 1'b0;
        tx_byte        = (state_reg == S_TX_LO) ? cur_word_reg[7:0] : cur_word_reg[15:8];
        baud_wrap      = (baud_reg == BAUD_LAST);

        // issue_reg[k] marks the k-th cycle after a new address appeared; data is valid at k = READ_LATENCY
        if (issue_reg[READ_LATENCY]) begin
            if (state_reg == S_TX_LO) begin
                next_word_next = SRAM_read_data;
            end else begin
                cur_word_next = SRAM_read_data;
            end
        end

        case (state_reg)
            S_IDLE: begin
                if (Start) begin
                    if (Word_count != '0) begin
                        addr_next      = Base_address;
                        remaining_next = Word_count;
                        issue_now      = 1'b1;
                        state_next     = S_FETCH;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                wait_next  = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (wait_reg == WAIT_LAST) begin
                    wait_next  = '0;
                    state_next = S_TX_HI;
                    tx_next    = 1'b0;
                    baud_next  = '0;
                    bit_next   = '0;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            S_TX_HI, S_TX_LO: begin
                if (baud_wrap) begin
                    baud_next = '0;
                    if (bit_reg == 4'd9) begin
                        bit_next = '0;
                        if (state_reg == S_TX_HI) begin
                            state_next     = S_TX_LO;
                            tx_next        = 1'b0;
                            remaining_next = remaining_reg - 1'b1;
                            // last word already in hand: no further read
                            if (remaining_reg != ADDR_W'(1)) begin
                                addr_next = addr_reg + 1'b1;
                                issue_now = 1'b1;
                            end
                        end else if (remaining_reg != '0) begin
                            state_next    = S_TX_HI;
                            tx_next       = 1'b0;
                            cur_word_next = next_word_reg;
                        end else begin
                            state_next = S_DONE;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_next = bit_reg + 1'b1;
                        tx_next  = (bit_reg == 4'd8) ? 1'b1 : tx_byte[bit_reg[2:0]];
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        issue_next = {issue_reg[READ_LATENCY-1:0], issue_now};
    end

    assign Busy         = (state_reg != S_IDLE);
    assign Done         = (state_reg == S_DONE);
    assign SRAM_address = addr_reg;
    assign SRAM_we_n    = 1'b1;
    assign UART_TX_O    = tx_reg;

endmodule

// File: tb/tb_sram_uart_dump.sv
// Bench for sram_uart_dump: SRAM model with 2-cycle read latency, UART receiver feeding a byte scoreboard,
// a table of dump runs, plus hand-written reset-abort sequence.
module tb_sram_uart_dump;
    localparam int CPB = 4;
    localparam int RL  = 2;
    localparam int AW  = 18;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic [AW-1:0] word_count = '0;
    logic          busy, done, sram_we_n, uart_tx;
    logic [AW-1:0] sram_address;
    logic [15:0]   sram_read_data = '0;
    logic [15:0]   rd_p1 = '0;
    logic [15:0]   mem [0:(1<<AW)-1];

    int total = 0;
    int passed = 0;
    int cyc = 0;

    sram_uart_dump #(
        .CLKS_PER_BIT(CPB),
        .READ_LATENCY(RL),
        .ADDR_W(AW)
    ) dut (
        .Clock(clk),
        .Resetn(resetn),
        .Start(start),
        .Base_address(base_address),
        .Word_count(word_count),
        .Busy(busy),
        .Done(done),
        .SRAM_address(sram_address),
        .SRAM_we_n(sram_we_n),
        .SRAM_read_data(sram_read_data),
        .UART_TX_O(uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // address driven in cycle k -> data valid in cycle k+2
    always @(posedge clk) begin
        rd_p1          <= mem[sram_address];
        sram_read_data <= rd_p1;
    end

    function automatic void check_eq(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endfunction

    // UART receiver, scoreboard pop, and per-cycle monitors
    logic [7:0]    exp_q[$];
    int            frame_starts[$];
    logic [AW-1:0] addr_log[$];
    logic [AW-1:0] last_addr = '0;
    bit            rx_active = 0;
    int            rx_off = 0;
    logic [9:0]    rx_bits = '0;
    logic [9:0]    first_frame_bits = '0;
    bit            first_frame_seen = 0;
    int            shape_err = 0;
    int            rx_bytes = 0;
    int            done_cnt = 0;
    int            we_low = 0;
    int            tx_low = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            rx_active = 0;
        end else if (!rx_active) begin
            if (uart_tx == 1'b0) begin
                rx_active = 1;
                rx_off    = 0;
                rx_bits   = '0;
                frame_starts.push_back(cyc);
            end
        end else begin
            rx_off++;
            if (rx_off % CPB == 0) rx_bits[rx_off / CPB] = uart_tx;
            else if (uart_tx != rx_bits[rx_off / CPB]) shape_err++;
        end
        if (rx_active && rx_off == 10 * CPB - 1) begin
            rx_active = 0;
            rx_bytes++;
            if (!first_frame_seen) begin
                first_frame_bits = rx_bits;
                first_frame_seen = 1;
            end
            check_eq("stop_bit", longint'(rx_bits[9]), 1);
            if (exp_q.size() == 0) begin
                check_eq("extra_byte", longint'(rx_bits[8:1]), 256);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check_eq("rx_byte", longint'(rx_bits[8:1]), longint'(e));
            end
        end
        if (done) done_cnt++;
        if (!sram_we_n) we_low++;
        if (resetn && !uart_tx) tx_low++;
        if (sram_address != last_addr) begin
            addr_log.push_back(sram_address);
            last_addr = sram_address;
        end
    end

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] count;
        bit            spurious;
        int            start_off;
        int            done_off;
    } vec_t;

    vec_t tbl [5];

    task automatic run_vec(input vec_t v, input string tag);
        int c, dcyc, n_done, n_bytes, n_we, n_txlow, bad;
        bit got;
        logic [AW-1:0] expaddr[$];
        for (int i = 0; i < int'(v.count); i++) begin
            logic [AW-1:0] a;
            logic [15:0] w;
            a = v.base + AW'(i);
            w = mem[a];
            expaddr.push_back(a);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
        n_done  = done_cnt;
        n_bytes = rx_bytes;
        n_we    = we_low;
        n_txlow = tx_low;
        frame_starts.delete();
        addr_log.delete();
        first_frame_seen = 0;
        shape_err = 0;

        @(posedge clk); #2;
        c = cyc;
        start = 1'b1;
        base_address = v.base;
        word_count = v.count;
        @(posedge clk); #2;
        start = 1'b0;
        base_address = AW'($urandom);
        word_count = AW'($urandom);
        @(negedge clk);
        check_eq({tag, "_busy_after_start"}, longint'(busy), 1);
        got = done;
        dcyc = cyc;
        for (int k = 0; k < v.done_off + 60 && !got; k++) begin
            @(posedge clk); #2;
            start = v.spurious && (cyc == c + 20 || cyc == c + 90 || cyc == c + v.done_off);
            @(negedge clk);
            if (done) begin
                got = 1;
                dcyc = cyc;
            end
        end
        @(posedge clk); #2;
        start = 1'b0;
        check_eq({tag, "_done_seen"}, longint'(got), 1);
        if (got) check_eq({tag, "_done_time"}, dcyc - c, v.done_off);
        @(negedge clk);
        check_eq({tag, "_busy_after_done"}, longint'(busy), 0);
        repeat (6) @(negedge clk);
        check_eq({tag, "_still_idle"}, longint'(busy), 0);
        check_eq({tag, "_done_pulses"}, done_cnt - n_done, 1);
        check_eq({tag, "_byte_count"}, rx_bytes - n_bytes, 2 * int'(v.count));
        check_eq({tag, "_sb_left"}, exp_q.size(), 0);
        check_eq({tag, "_we_low"}, we_low - n_we, 0);
        check_eq({tag, "_shape_err"}, shape_err, 0);
        if (v.count != '0) begin
            if (frame_starts.size() > 0) check_eq({tag, "_first_start"}, frame_starts[0] - c, v.start_off);
            else check_eq({tag, "_first_start"}, -1, v.start_off);
            bad = 0;
            for (int i = 1; i < frame_starts.size(); i++)
                if (frame_starts[i] - frame_starts[i-1] != 10 * CPB) bad++;
            check_eq({tag, "_frame_gaps"}, bad, 0);
        end else begin
            check_eq({tag, "_line_idle"}, tx_low - n_txlow, 0);
        end
        bad = (addr_log.size() == expaddr.size()) ? 0 : 1;
        for (int i = 0; i < addr_log.size() && i < expaddr.size(); i++)
            if (addr_log[i] != expaddr[i]) bad++;
        check_eq({tag, "_addr_seq"}, bad, 0);
        exp_q.delete();
        $display("run %s base=%0d words=%0d done_at=+%0d bytes=%0d", tag, v.base, v.count,
                 dcyc - c, rx_bytes - n_bytes);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, n_done, n_bytes;
        mem[100]    = 16'hA55A;
        mem[101]    = 16'h0F01;
        mem[262143] = 16'hBEEF;
        mem[0]      = 16'h1234;
        mem[1]      = 16'hC3C3;
        for (int i = 300; i < 303; i++) mem[i] = 16'($urandom);

        tbl[0] = '{base: 18'd100,    count: 18'd2, spurious: 1'b0, start_off: 3, done_off: 163};
        tbl[1] = '{base: 18'd262143, count: 18'd2, spurious: 1'b0, start_off: 3, done_off: 163};
        tbl[2] = '{base: 18'd50,     count: 18'd0, spurious: 1'b0, start_off: 0, done_off: 1};
        tbl[3] = '{base: 18'd100,    count: 18'd2, spurious: 1'b1, start_off: 3, done_off: 163};
        tbl[4] = '{base: 18'd300,    count: 18'd3, spurious: 1'b0, start_off: 3, done_off: 243};

        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        check_eq("reset_tx", longint'(uart_tx), 1);
        check_eq("reset_busy", longint'(busy), 0);
        check_eq("reset_done", longint'(done), 0);
        check_eq("reset_addr", longint'(sram_address), 0);
        check_eq("reset_we_n", longint'(sram_we_n), 1);

        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
            if (i == 0) check_eq("frame_a5_shape", longint'(first_frame_bits), longint'(10'b1101001010));
        end

        // reset pulse during bit 5 of the second byte
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        n_bytes = rx_bytes;
        @(posedge clk); #2;
        c = cyc;
        start = 1'b1;
        base_address = 18'd100;
        word_count = 18'd2;
        @(posedge clk); #2;
        start = 1'b0;
        while (cyc < c + 64) begin
            @(posedge clk); #2;
        end
        resetn = 1'b0;
        n_done = done_cnt;
        @(posedge clk); #2;
        resetn = 1'b1;
        @(negedge clk);
        check_eq("rst_tx_high", longint'(uart_tx), 1);
        check_eq("rst_busy_low", longint'(busy), 0);
        check_eq("rst_no_done", longint'(done), 0);
        repeat (20) @(negedge clk);
        check_eq("rst_done_pulses", done_cnt - n_done, 0);
        check_eq("rst_bytes_before_abort", rx_bytes - n_bytes, 1);
        exp_q.delete();
        $display("run reset_abort base=100 words=2 bytes=%0d", rx_bytes - n_bytes);

        run_vec(tbl[0], "after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
